// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: forward-select codes, stall FSM states
// and the per-operand stall-need type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef logic [1:0] need_t;

endpackage

// File: rtl/branch_operand_classify.sv
// Classifies one branch source operand against the EX/MEM/WB writers,
// youngest writer first, yielding a forward select and a stall-cycle need.
module branch_operand_classify
  import hazard_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int WB_FWD = 1
) (
  input  logic [RA_W-1:0] src,
  input  logic            ex_regwr,
  input  logic            ex_load,
  input  logic [RA_W-1:0] ex_reg,
  input  logic            mem_regwr,
  input  logic            mem_load,
  input  logic [RA_W-1:0] mem_reg,
  input  logic            wb_regwr,
  input  logic [RA_W-1:0] wb_reg,
  output logic [1:0]      sel,
  output need_t           need
);

  always_comb begin
    sel  = FWD_RF;
    need = 2'd0;
    // Register 0 is hardwired, so it never creates a dependency.
    if (src != '0) begin
      if (ex_regwr && (ex_reg == src)) begin
        need = ex_load ? 2'd2 : 2'd1;
      end else if (mem_regwr && (mem_reg == src)) begin
        if (mem_load) begin
          need = 2'd1;
        end else begin
          sel = FWD_MEM;
        end
      end else if (wb_regwr && (wb_reg == src)) begin
        sel = (WB_FWD != 0) ? FWD_WB : FWD_RF;
      end
    end
  end

endmodule

// File: rtl/id_branch_fwd_ctrl.sv
// ID-stage branch operand forwarding and stall controller: per-port selects,
// an exact-length stall sequencer and a saturating stall-cycle counter.
module id_branch_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int NPORT  = 2,
  parameter int WB_FWD = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_branch,
  input  logic                  id_kill,
  input  logic [NPORT*RA_W-1:0] id_src,
  input  logic                  ex_regwr,
  input  logic                  ex_load,
  input  logic [RA_W-1:0]       ex_reg,
  input  logic                  mem_regwr,
  input  logic                  mem_load,
  input  logic [RA_W-1:0]       mem_reg,
  input  logic                  wb_regwr,
  input  logic [RA_W-1:0]       wb_reg,
  output logic [NPORT*2-1:0]    fwd_sel,
  output logic                  stall,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic [1:0]         portSel  [NPORT];
  need_t              portNeed [NPORT];
  need_t              needMax;
  state_e             state_q, state_d;
  logic [1:0]         rem_q, rem_d;
  logic [CNT_W-1:0]   stallCnt_q;
  logic               stallInt;
  logic [NPORT*2-1:0] fwdInt;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    branch_operand_classify #(
      .RA_W   (RA_W),
      .WB_FWD (WB_FWD)
    ) u_classify (
      .src       (id_src[p*RA_W +: RA_W]),
      .ex_regwr  (ex_regwr),
      .ex_load   (ex_load),
      .ex_reg    (ex_reg),
      .mem_regwr (mem_regwr),
      .mem_load  (mem_load),
      .mem_reg   (mem_reg),
      .wb_regwr  (wb_regwr),
      .wb_reg    (wb_reg),
      .sel       (portSel[p]),
      .need      (portNeed[p])
    );
  end

  always_comb begin
    needMax = 2'd0;
    for (int p = 0; p < NPORT; p++) begin
      if (portNeed[p] > needMax) needMax = portNeed[p];
    end
  end

  // HOLD ignores the pipeline inputs: the injected bubbles make the
  // remaining wait fully determined by the count loaded on entry.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    stallInt = 1'b0;
    fwdInt   = '0;
    case (state_q)
      IDLE: begin
        if (id_branch && !id_kill) begin
          if (needMax != 2'd0) begin
            stallInt = 1'b1;
            rem_d    = needMax - 2'd1;
            if (needMax > 2'd1) state_d = HOLD;
          end else begin
            for (int p = 0; p < NPORT; p++) fwdInt[p*2 +: 2] = portSel[p];
          end
        end
      end
      HOLD: begin
        if (id_kill) begin
          state_d = IDLE;
          rem_d   = 2'd0;
        end else begin
          stallInt = 1'b1;
          rem_d    = rem_q - 2'd1;
          if (rem_q <= 2'd1) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= 2'd0;
      stallCnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (stallInt && (stallCnt_q != {CNT_W{1'b1}})) stallCnt_q <= stallCnt_q + 1'b1;
    end
  end

  // Outputs are gated by rst_n so an asserted reset silences them at once.
  assign stall     = rst_n & stallInt;
  assign bubble    = stall;
  assign fwd_sel   = rst_n ? fwdInt : '0;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_id_branch_fwd_ctrl.sv
// Self-checking bench: directed hazard scenarios then randomized traffic,
// compared against a countdown-based reference model of the branch stalls.
module tb_id_branch_fwd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        idBranch, idKill;
  logic [9:0]  idSrc;
  logic        exRegwr, exLoad, memRegwr, memLoad, wbRegwr;
  logic [4:0]  exReg, memReg, wbReg;

  logic [3:0]  fwdSelA, fwdSelB;
  logic        stallA, stallB, bubbleA, bubbleB;
  logic [15:0] stallCntA;
  logic [3:0]  stallCntB;

  int passCount  = 0;
  int checkCount = 0;

  int modelRem  = 0;
  int modelCntA = 0;
  int modelCntB = 0;
  bit expStall;
  int expMaxNeed;

  id_branch_fwd_ctrl dutA (
    .clk(clk), .rst_n(rst_n), .id_branch(idBranch), .id_kill(idKill), .id_src(idSrc),
    .ex_regwr(exRegwr), .ex_load(exLoad), .ex_reg(exReg),
    .mem_regwr(memRegwr), .mem_load(memLoad), .mem_reg(memReg),
    .wb_regwr(wbRegwr), .wb_reg(wbReg),
    .fwd_sel(fwdSelA), .stall(stallA), .bubble(bubbleA), .stall_cnt(stallCntA)
  );

  id_branch_fwd_ctrl #(.WB_FWD(0), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .id_branch(idBranch), .id_kill(idKill), .id_src(idSrc),
    .ex_regwr(exRegwr), .ex_load(exLoad), .ex_reg(exReg),
    .mem_regwr(memRegwr), .mem_load(memLoad), .mem_reg(memReg),
    .wb_regwr(wbRegwr), .wb_reg(wbReg),
    .fwd_sel(fwdSelB), .stall(stallB), .bubble(bubbleB), .stall_cnt(stallCntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One operand judged from the hazard rules, youngest writer first.
  function automatic void refPort(input logic [4:0] src, input bit wbFwd,
                                  output logic [1:0] sel, output int need);
    sel  = 2'b00;
    need = 0;
    if (src == 5'd0) return;
    if (exRegwr && exReg == src) begin
      need = exLoad ? 2 : 1;
      return;
    end
    if (memRegwr && memReg == src) begin
      if (memLoad) need = 1;
      else sel = 2'b01;
      return;
    end
    if (wbRegwr && wbReg == src) sel = wbFwd ? 2'b10 : 2'b00;
  endfunction

  task automatic applyStimulus(input bit br, input bit kill, input logic [4:0] src0,
                               input logic [4:0] src1, input bit exW, input bit exL,
                               input logic [4:0] exR, input bit memW, input bit memL,
                               input logic [4:0] memR, input bit wbW, input logic [4:0] wbR);
    idBranch = br;   idKill = kill;  idSrc = {src1, src0};
    exRegwr  = exW;  exLoad = exL;   exReg = exR;
    memRegwr = memW; memLoad = memL; memReg = memR;
    wbRegwr  = wbW;  wbReg = wbR;
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] sa0, sa1, sb0, sb1;
    int n0, n1, d0, d1;
    logic [3:0] expFwdA, expFwdB;
    bit fwdLive;
    #3;
    refPort(idSrc[4:0], 1'b1, sa0, n0);
    refPort(idSrc[9:5], 1'b1, sa1, n1);
    refPort(idSrc[4:0], 1'b0, sb0, d0);
    refPort(idSrc[9:5], 1'b0, sb1, d1);
    expMaxNeed = (n0 > n1) ? n0 : n1;
    if (modelRem > 0) expStall = !idKill;
    else expStall = idBranch && !idKill && (expMaxNeed > 0);
    fwdLive = (modelRem == 0) && idBranch && !idKill && (expMaxNeed == 0);
    expFwdA = fwdLive ? {sa1, sa0} : 4'b0000;
    expFwdB = fwdLive ? {sb1, sb0} : 4'b0000;
    checkVal({tag, "_stallA"},  32'(stallA),    32'(expStall));
    checkVal({tag, "_stallB"},  32'(stallB),    32'(expStall));
    checkVal({tag, "_bubbleA"}, 32'(bubbleA),   32'(expStall));
    checkVal({tag, "_bubbleB"}, 32'(bubbleB),   32'(expStall));
    checkVal({tag, "_fwdA"},    32'(fwdSelA),   32'(expFwdA));
    checkVal({tag, "_fwdB"},    32'(fwdSelB),   32'(expFwdB));
    checkVal({tag, "_cntA"},    32'(stallCntA), 32'(modelCntA));
    checkVal({tag, "_cntB"},    32'(stallCntB), 32'(modelCntB));
  endtask

  task automatic nextCycle();
    bit killNow;
    killNow = idKill;
    @(posedge clk);
    if (modelRem > 0) modelRem = killNow ? 0 : modelRem - 1;
    else if (expStall) modelRem = expMaxNeed - 1;
    if (expStall) begin
      if (modelCntA < 65535) modelCntA++;
      if (modelCntB < 15) modelCntB++;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(1, 0, 5'd5, 5'd0, 1, 1, 5'd5, 0, 0, 5'd0, 0, 5'd0);
    #1 rst_n = 1'b0;
    #1;
    checkVal("rst_stallA", 32'(stallA), 0);
    checkVal("rst_bubbleB", 32'(bubbleB), 0);
    checkVal("rst_fwdA", 32'(fwdSelA), 0);
    checkVal("rst_cntA", 32'(stallCntA), 0);
    checkVal("rst_cntB", 32'(stallCntB), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] EX ALU dependency");
    applyStimulus(1, 0, 5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 5'd0, 0, 5'd0);
    checkOutput("t1_c0");
    checkVal("t1_stall0", 32'(stallA), 1);
    nextCycle();
    applyStimulus(1, 0, 5'd5, 5'd0, 0, 0, 5'd0, 1, 0, 5'd5, 0, 5'd0);
    checkOutput("t1_c1");
    checkVal("t1_fwd", 32'(fwdSelA[1:0]), 32'(2'b01));
    checkVal("t1_stall1", 32'(stallA), 0);
    checkVal("t1_cnt", 32'(stallCntA), 1);
    nextCycle();

    $display("[TB] EX load dependency");
    applyStimulus(1, 0, 5'd0, 5'd5, 1, 1, 5'd5, 0, 0, 5'd0, 0, 5'd0);
    checkOutput("t2_c0");
    checkVal("t2_stall0", 32'(stallA), 1);
    nextCycle();
    applyStimulus(1, 0, 5'd0, 5'd5, 0, 0, 5'd0, 1, 1, 5'd5, 0, 5'd0);
    checkOutput("t2_c1");
    checkVal("t2_stall1", 32'(stallA), 1);
    checkVal("t2_fwd1", 32'(fwdSelA), 0);
    nextCycle();
    applyStimulus(1, 0, 5'd0, 5'd5, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd5);
    checkOutput("t2_c2");
    checkVal("t2_stall2", 32'(stallA), 0);
    checkVal("t2_fwdA", 32'(fwdSelA[3:2]), 32'(2'b10));
    checkVal("t2_fwdB", 32'(fwdSelB[3:2]), 32'(2'b00));
    checkVal("t2_cnt", 32'(stallCntA), 3);
    nextCycle();

    $display("[TB] MEM and WB both write r7");
    applyStimulus(1, 0, 5'd7, 5'd7, 0, 0, 5'd0, 1, 0, 5'd7, 1, 5'd7);
    checkOutput("t3_mem");
    checkVal("t3_fwdMem", 32'(fwdSelA), 32'(4'b0101));
    nextCycle();
    applyStimulus(1, 0, 5'd7, 5'd7, 0, 0, 5'd0, 0, 0, 5'd7, 1, 5'd7);
    checkOutput("t3_wb");
    checkVal("t3_fwdWbA", 32'(fwdSelA), 32'(4'b1010));
    checkVal("t3_fwdWbB", 32'(fwdSelB), 32'(4'b0000));
    nextCycle();

    $display("[TB] r0 never stalls");
    applyStimulus(1, 0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 5'd0, 0, 5'd0);
    checkOutput("t4_r0");
    checkVal("t4_stall", 32'(stallA), 0);
    nextCycle();

    $display("[TB] kill during HOLD");
    applyStimulus(1, 0, 5'd9, 5'd0, 1, 1, 5'd9, 0, 0, 5'd0, 0, 5'd0);
    checkOutput("t5_c0");
    nextCycle();
    applyStimulus(1, 1, 5'd9, 5'd0, 0, 0, 5'd0, 1, 1, 5'd9, 0, 5'd0);
    checkOutput("t5_kill");
    checkVal("t5_stallKill", 32'(stallA), 0);
    nextCycle();
    applyStimulus(1, 0, 5'd3, 5'd0, 0, 0, 5'd0, 1, 0, 5'd3, 0, 5'd0);
    checkOutput("t5_idle");
    checkVal("t5_fwdIdle", 32'(fwdSelA), 32'(4'b0001));
    checkVal("t5_cnt", 32'(stallCntA), 4);
    nextCycle();

    $display("[TB] counter saturation");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 5'd4, 5'd0, 1, 0, 5'd4, 0, 0, 5'd0, 0, 5'd0);
      checkOutput("t6_run");
      nextCycle();
    end
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
    checkOutput("t6_sat");
    checkVal("t6_cntB", 32'(stallCntB), 15);
    checkVal("t6_cntA", 32'(stallCntA), 24);
    nextCycle();

    $display("[TB] reset during HOLD");
    applyStimulus(1, 0, 5'd6, 5'd0, 1, 1, 5'd6, 0, 0, 5'd0, 0, 5'd0);
    checkOutput("t7_c0");
    nextCycle();
    applyStimulus(1, 0, 5'd6, 5'd0, 0, 0, 5'd0, 1, 1, 5'd6, 0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    checkVal("t7_stallA", 32'(stallA), 0);
    checkVal("t7_bubbleA", 32'(bubbleA), 0);
    checkVal("t7_stallB", 32'(stallB), 0);
    checkVal("t7_fwdA", 32'(fwdSelA), 0);
    checkVal("t7_cntA", 32'(stallCntA), 0);
    checkVal("t7_cntB", 32'(stallCntB), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    modelRem  = 0;
    modelCntA = 0;
    modelCntB = 0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(3) != 0, $urandom_range(7) == 0,
                    5'($urandom_range(7)), 5'($urandom_range(7)),
                    $urandom_range(1) == 1, $urandom_range(1) == 1, 5'($urandom_range(7)),
                    $urandom_range(1) == 1, $urandom_range(1) == 1, 5'($urandom_range(7)),
                    $urandom_range(1) == 1, 5'($urandom_range(7)));
      checkOutput("rnd");
      nextCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
